fetch_buffer: RTL and testbench

Instruction-side bus front end sitting directly upstream of the IF/ID stage: it services the stage's word fetch requests over a single-outstanding memory bus. It holds a two-entry word buffer with tag-checked zero-latency hits, so unaligned and compressed re-reads of the same word cost no bus cycles. When the bus is idle, it prefetches the next sequential word.

---
 rtl/fetch_buffer_if.sv | 26 ++
 rtl/fetch_buffer.sv | 130 +++++++++++++
 tb/tb_fetch_buffer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_if.sv
// Handshake bundle between IF/ID, the fetch buffer and the instruction memory bus.
// The slave modport is the fetch buffer's view; master is the environment's view.
interface fetch_buffer_if;
  logic        instruction_request_i;
  logic [31:0] instruction_addr_i;
  logic        flush_bus_i;
  logic        invalidate_i;
  logic        instruction_response_o;
  logic [31:0] instruction_data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  modport slave (
    input  instruction_request_i, instruction_addr_i, flush_bus_i, invalidate_i,
    input  mem_ack_i, mem_data_i,
    output instruction_response_o, instruction_data_o, mem_req_o, mem_addr_o
  );

  modport master (
    output instruction_request_i, instruction_addr_i, flush_bus_i, invalidate_i,
    output mem_ack_i, mem_data_i,
    input  instruction_response_o, instruction_data_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry tag-checked instruction word buffer with zero-latency hits, a
// single-outstanding memory bus and optional sequential next-word prefetch.
module fetch_buffer #(
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_PREFETCH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_mem_addr;
  logic [31:0] w_mem_addr_nxt;

  logic [1:0]  r_valid;
  logic [29:0] r_tag  [2];
  logic [31:0] r_data [2];
  logic        r_lru;
  logic        r_stale;

  logic [29:0] w_tag;
  logic [29:0] w_next_tag;
  logic [1:0]  w_hit_e;
  logic        w_hit;
  logic        w_hit_idx;
  logic        w_resp;
  logic        w_next_res;
  logic        w_busy;
  logic        w_fill_ack;
  logic        w_fill;
  logic        w_victim;
  logic        w_unused_lsb;

  assign w_unused_lsb = ^bus.instruction_addr_i[1:0];

  assign w_tag      = bus.instruction_addr_i[31:2];
  assign w_next_tag = w_tag + 30'd1;
  assign w_hit_e[0] = bus.instruction_request_i & r_valid[0] & (r_tag[0] == w_tag);
  assign w_hit_e[1] = bus.instruction_request_i & r_valid[1] & (r_tag[1] == w_tag);
  assign w_hit      = |w_hit_e;
  assign w_hit_idx  = w_hit_e[1];
  assign w_resp     = w_hit & ~bus.invalidate_i;
  assign w_next_res = (r_valid[0] & (r_tag[0] == w_next_tag)) |
                      (r_valid[1] & (r_tag[1] == w_next_tag));

  assign w_busy     = (r_state != S_IDLE);
  assign w_fill_ack = w_busy & bus.mem_ack_i;
  assign w_fill     = w_fill_ack & ~r_stale & ~bus.invalidate_i;
  // Victim steers away from whichever entry is being hit this very cycle.
  assign w_victim   = w_hit ? ~w_hit_idx : r_lru;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_addr_nxt = r_mem_addr;
    unique case (r_state)
      S_IDLE: begin
        if (bus.instruction_request_i && !w_hit) begin
          w_state_nxt    = S_FETCH;
          w_mem_addr_nxt = {w_tag, 2'b00};
        end else if (PREFETCH_EN && w_resp && !w_next_res && !bus.flush_bus_i) begin
          w_state_nxt    = S_PREFETCH;
          w_mem_addr_nxt = {w_next_tag, 2'b00};
        end
      end
      S_FETCH, S_PREFETCH: begin
        if (bus.mem_ack_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.instruction_response_o = w_resp;
    bus.instruction_data_o     = w_resp ? r_data[w_hit_idx] : '0;
    bus.mem_req_o              = w_busy;
    bus.mem_addr_o             = r_mem_addr;
  end

  // Invalidate wins over a same-cycle fill; an outstanding cycle is marked
  // stale so its late data never repopulates a cleared buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_lru   <= 1'b0;
      r_stale <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (bus.invalidate_i) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[w_victim] <= 1'b1;
      end

      if (w_fill) begin
        r_tag[w_victim]  <= r_mem_addr[31:2];
        r_data[w_victim] <= bus.mem_data_i;
        r_lru            <= ~w_victim;
      end else if (w_hit) begin
        r_lru <= ~w_hit_idx;
      end

      if (w_fill_ack) begin
        r_stale <= 1'b0;
      end else if (bus.invalidate_i && w_busy) begin
        r_stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: inputs change on the falling edge and
// outputs are sampled 1ns later, so combinational hits are checked in-cycle.
module tb_fetch_buffer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  fetch_buffer_if bus ();

  fetch_buffer #(.PREFETCH_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [31:0] D000  = 32'h0000_0013;
  localparam logic [31:0] D004  = 32'h0000_0093;
  localparam logic [31:0] D100  = 32'hCAFE_0100;
  localparam logic [31:0] D104  = 32'hCAFE_0104;
  localparam logic [31:0] D200  = 32'h1111_0200;
  localparam logic [31:0] D204  = 32'h2222_0204;
  localparam logic [31:0] D208  = 32'h3333_0208;
  localparam logic [31:0] D300  = 32'h4444_0300;
  localparam logic [31:0] D400  = 32'h5555_0400;
  localparam logic [31:0] D404  = 32'h6666_0404;
  localparam logic [31:0] D500A = 32'hDEAD_0500;
  localparam logic [31:0] D500B = 32'hBEEF_0500;
  localparam logic [31:0] D500C = 32'hF00D_0500;
  localparam logic [31:0] D504  = 32'h7777_0504;

  task automatic step();
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    bus.flush_bus_i = 1'b0;
    bus.invalidate_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.instruction_request_i = 1'b0;
    bus.instruction_addr_i = '0;
    bus.flush_bus_i = 1'b0;
    bus.invalidate_i = 1'b0;
    bus.mem_ack_i = 1'b0;
    bus.mem_data_i = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.instruction_response_o !== 1'b0) $display("FAIL reset_resp got %b exp 0", bus.instruction_response_o); else n_pass++;
    n_checks++; if (bus.instruction_data_o !== 32'h0) $display("FAIL reset_data got %h exp 0", bus.instruction_data_o); else n_pass++;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL reset_req got %b exp 0", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 32'h0) $display("FAIL reset_addr got %h exp 0", bus.mem_addr_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    step(); bus.instruction_request_i = 1'b1; bus.instruction_addr_i = 32'h0; #1;
    n_checks++; if (bus.instruction_response_o !== 1'b0) $display("FAIL cold_noresp got %b exp 0", bus.instruction_response_o); else n_pass++;
    step(); #1;
    n_checks++; if (bus.mem_req_o !== 1'b1) $display("FAIL cold_req1 got %b exp 1", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 32'h0) $display("FAIL cold_addr got %h exp 0", bus.mem_addr_o); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D000; #1;
    n_checks++; if (bus.mem_req_o !== 1'b1) $display("FAIL cold_req2 got %b exp 1", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.instruction_response_o !== 1'b0) $display("FAIL cold_resp_ack got %b exp 0", bus.instruction_response_o); else n_pass++;
    step(); #1;
    n_checks++; if (bus.instruction_response_o !== 1'b1) $display("FAIL cold_resp got %b exp 1", bus.instruction_response_o); else n_pass++;
    n_checks++; if (bus.instruction_data_o !== D000) $display("FAIL cold_data got %h exp %h", bus.instruction_data_o, D000); else n_pass++;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL cold_req_drop got %b exp 0", bus.mem_req_o); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D004; #1;
    n_checks++; if (bus.mem_req_o !== 1'b1) $display("FAIL cold_pf_req got %b exp 1", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 32'h4) $display("FAIL cold_pf_addr got %h exp 4", bus.mem_addr_o); else n_pass++;
    step(); #1;
    n_checks++; if (bus.instruction_response_o !== 1'b1) $display("FAIL cold_idem got %b exp 1", bus.instruction_response_o); else n_pass++;
    step(); #1;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL cold_no_repf got %b exp 0", bus.mem_req_o); else n_pass++;
  endtask

  task automatic test_unaligned();
    step(); bus.instruction_addr_i = 32'h100;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D100; #1;
    n_checks++; if (bus.mem_addr_o !== 32'h100) $display("FAIL ua_fetch_addr got %h exp 100", bus.mem_addr_o); else n_pass++;
    step(); #1;
    n_checks++; if (bus.instruction_data_o !== D100) $display("FAIL ua_fill_data got %h exp %h", bus.instruction_data_o, D100); else n_pass++;
    step(); bus.instruction_addr_i = 32'h102; bus.mem_ack_i = 1'b1; bus.mem_data_i = D104; #1;
    n_checks++; if (bus.instruction_response_o !== 1'b1) $display("FAIL ua_resp got %b exp 1", bus.instruction_response_o); else n_pass++;
    n_checks++; if (bus.instruction_data_o !== D100) $display("FAIL ua_data got %h exp %h", bus.instruction_data_o, D100); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 32'h104) $display("FAIL ua_bus_addr got %h exp 104", bus.mem_addr_o); else n_pass++;
    step(); step(); #1;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL ua_no_req got %b exp 0", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.instruction_data_o !== D100) $display("FAIL ua_data_held got %h exp %h", bus.instruction_data_o, D100); else n_pass++;
  endtask

  task automatic test_prefetch();
    step(); bus.instruction_addr_i = 32'h200;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D200;
    step(); #1;
    n_checks++; if (bus.instruction_data_o !== D200) $display("FAIL pf_hit200 got %h exp %h", bus.instruction_data_o, D200); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D204; #1;
    n_checks++; if (bus.mem_addr_o !== 32'h204) $display("FAIL pf_addr204 got %h exp 204", bus.mem_addr_o); else n_pass++;
    step(); bus.instruction_addr_i = 32'h204; #1;
    n_checks++; if (bus.instruction_response_o !== 1'b1) $display("FAIL pf_resp204 got %b exp 1", bus.instruction_response_o); else n_pass++;
    n_checks++; if (bus.instruction_data_o !== D204) $display("FAIL pf_data204 got %h exp %h", bus.instruction_data_o, D204); else n_pass++;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL pf_noreq204 got %b exp 0", bus.mem_req_o); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D208; #1;
    n_checks++; if (bus.mem_req_o !== 1'b1) $display("FAIL pf_req208 got %b exp 1", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 32'h208) $display("FAIL pf_addr208 got %h exp 208", bus.mem_addr_o); else n_pass++;
    step();
  endtask

  task automatic test_flush();
    step(); bus.instruction_addr_i = 32'h300;
    step(); bus.flush_bus_i = 1'b1; bus.instruction_addr_i = 32'h400; #1;
    n_checks++; if (bus.mem_addr_o !== 32'h300) $display("FAIL fl_addr300 got %h exp 300", bus.mem_addr_o); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D300; #1;
    n_checks++; if (bus.mem_addr_o !== 32'h300) $display("FAIL fl_held300 got %h exp 300", bus.mem_addr_o); else n_pass++;
    step(); #1;
    n_checks++; if (bus.instruction_response_o !== 1'b0) $display("FAIL fl_noresp400 got %b exp 0", bus.instruction_response_o); else n_pass++;
    step(); bus.instruction_addr_i = 32'h300; #1;
    n_checks++; if (bus.mem_addr_o !== 32'h400) $display("FAIL fl_addr400 got %h exp 400", bus.mem_addr_o); else n_pass++;
    n_checks++; if (bus.instruction_data_o !== D300) $display("FAIL fl_written300 got %h exp %h", bus.instruction_data_o, D300); else n_pass++;
    step(); bus.instruction_addr_i = 32'h400; bus.mem_ack_i = 1'b1; bus.mem_data_i = D400; #1;
    n_checks++; if (bus.instruction_response_o !== 1'b0) $display("FAIL fl_early400 got %b exp 0", bus.instruction_response_o); else n_pass++;
    step(); #1;
    n_checks++; if (bus.instruction_data_o !== D400) $display("FAIL fl_data400 got %h exp %h", bus.instruction_data_o, D400); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D404;
    step();
  endtask

  task automatic test_invalidate();
    step(); bus.instruction_addr_i = 32'h500;
    step(); bus.invalidate_i = 1'b1; #1;
    n_checks++; if (bus.mem_addr_o !== 32'h500) $display("FAIL inv_addr500 got %h exp 500", bus.mem_addr_o); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D500A;
    step(); #1;
    n_checks++; if (bus.instruction_response_o !== 1'b0) $display("FAIL inv_discard got %b exp 0", bus.instruction_response_o); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D500B; #1;
    n_checks++; if (bus.mem_req_o !== 1'b1) $display("FAIL inv_refetch_req got %b exp 1", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 32'h500) $display("FAIL inv_refetch_addr got %h exp 500", bus.mem_addr_o); else n_pass++;
    step(); #1;
    n_checks++; if (bus.instruction_data_o !== D500B) $display("FAIL inv_refill got %h exp %h", bus.instruction_data_o, D500B); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D504;
    step(); bus.invalidate_i = 1'b1; #1;
    n_checks++; if (bus.instruction_response_o !== 1'b0) $display("FAIL inv_hit_suppress got %b exp 0", bus.instruction_response_o); else n_pass++;
    step(); #1;
    n_checks++; if (bus.instruction_response_o !== 1'b0) $display("FAIL inv_cleared got %b exp 0", bus.instruction_response_o); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D500C; #1;
    n_checks++; if (bus.mem_addr_o !== 32'h500) $display("FAIL inv_fetch2_addr got %h exp 500", bus.mem_addr_o); else n_pass++;
  endtask

  task automatic test_async_reset();
    step(); #1;
    n_checks++; if (bus.instruction_data_o !== D500C) $display("FAIL ar_pre_data got %h exp %h", bus.instruction_data_o, D500C); else n_pass++;
    step(); #1;
    n_checks++; if (bus.mem_req_o !== 1'b1) $display("FAIL ar_pre_req got %b exp 1", bus.mem_req_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL ar_req_drop got %b exp 0", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 32'h0) $display("FAIL ar_addr_drop got %h exp 0", bus.mem_addr_o); else n_pass++;
    n_checks++; if (bus.instruction_response_o !== 1'b0) $display("FAIL ar_resp_drop got %b exp 0", bus.instruction_response_o); else n_pass++;
    step(); rst_n = 1'b1; bus.instruction_request_i = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_data_i = D504;
    step(); bus.instruction_request_i = 1'b1; bus.instruction_addr_i = 32'h500; #1;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL ar_late_ack got %b exp 0", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.instruction_response_o !== 1'b0) $display("FAIL ar_valid_clear got %b exp 0", bus.instruction_response_o); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D500A; #1;
    n_checks++; if (bus.mem_addr_o !== 32'h500) $display("FAIL ar_refetch got %h exp 500", bus.mem_addr_o); else n_pass++;
    step(); #1;
    n_checks++; if (bus.instruction_data_o !== D500A) $display("FAIL ar_refill got %h exp %h", bus.instruction_data_o, D500A); else n_pass++;
    step(); bus.mem_ack_i = 1'b1; bus.mem_data_i = D504;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_cold_miss();
    test_unaligned();
    test_prefetch();
    test_flush();
    test_invalidate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
